hood_state_controller: RTL
==========================

HOOD_STATE_CONTROLLER -- requirements
Module: hood_state_controller

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: clk rising edge; rst_n sampled only on clk rising edge.
REQ-002 SHALL have port `clk`: input, 1 bit, system clock.
REQ-003 SHALL have port `rst_n`: input, 1 bit, synchronous active-low reset.
REQ-004 SHALL have port `tick_1s`: input, 1 bit, one-cycle pulse once per second.
REQ-005 SHALL have port `power_btn`: input, 1 bit, debounced one-cycle press pulse.
REQ-006 SHALL have port `menu_btn`: input, 1 bit, debounced one-cycle press pulse.
REQ-007 SHALL have ports `level1_btn`, `level2_btn`, `level3_btn` and `clean_btn`: input, 1 bit each, debounced one-cycle press pulses.
REQ-008 SHALL have port `state`: output, 3 bits, registered current state, encoded as in REQ-011.
REQ-009 SHALL have port `countdown`: output, 8 bits, registered seconds remaining in timed states; 0 otherwise.
REQ-010 SHALL have port `third_used`: output, 1 bit, high once THIRD_LEVEL has been entered since the last power-on.

Function
REQ-011 SHALL encode states as: OFF=000, STANDBY=001, MODE_SELECT=010, FIRST_LEVEL=011, SECOND_LEVEL=100, THIRD_LEVEL=101, SELF_CLEAN=110.
REQ-012 SHALL resolve simultaneous buttons by priority: power > menu > level3 > level2 > level1 > clean; only the highest-priority press acts in a cycle.
REQ-013 SHALL make every transition take effect on the clk edge that samples the press, so `state` updates one cycle after the pulse.
REQ-014 SHALL, from OFF, go to STANDBY on power; all other inputs are ignored.
REQ-015 SHALL make power, in any state other than OFF, go to OFF, clear `countdown`, and clear `third_used`.
REQ-016 SHALL, from STANDBY, go to MODE_SELECT on menu and load `countdown`=10.
REQ-017 SHALL, from MODE_SELECT, make: level1 -> FIRST_LEVEL; level2 -> SECOND_LEVEL; level3 -> THIRD_LEVEL only if `third_used`=0 (otherwise ignored, state held); clean -> SELF_CLEAN; menu -> STANDBY.
REQ-018 SHALL give MODE_SELECT an idle timeout: decrement `countdown` on each tick_1s; when a tick arrives with `countdown`=1, go to STANDBY with `countdown`=0.
REQ-019 SHALL, in FIRST_LEVEL, go to SECOND_LEVEL on level2; SHALL, in SECOND_LEVEL, go to FIRST_LEVEL on level1; menu in either -> STANDBY; `countdown`=0 in both.
REQ-020 SHALL, on entry to THIRD_LEVEL, load `countdown`=60 and set `third_used`=1.
REQ-021 SHALL decrement `countdown` on each tick_1s in THIRD_LEVEL; a tick with `countdown`=1 -> SECOND_LEVEL, `countdown`=0.
REQ-022 SHALL ignore level1, level2, level3, clean and menu in THIRD_LEVEL; only power and expiry leave it.
REQ-023 SHALL, on entry to SELF_CLEAN, load `countdown`=180 and decrement on each tick; a tick with `countdown`=1 -> STANDBY, `countdown`=0; only power may interrupt.
REQ-024 SHALL ignore a tick_1s on the same cycle as an accepted button transition; the new state's load value wins, giving exactly N ticks after entry.
REQ-025 SHALL never let `countdown` decrement below 0 or wrap; in untimed states it holds 0.
REQ-026 SHALL, if `state` ever holds 111, go to OFF on the next edge with `countdown`=0 and `third_used`=0.
REQ-027 SHALL keep `third_used` through STANDBY, MODE_SELECT and level changes; only OFF or reset clears it.

Reset
REQ-028 SHALL, when rst_n=0 at a clk edge, set `state`=OFF, `countdown`=0 and `third_used`=0, regardless of other inputs or the current state, including mid-countdown.
REQ-029 SHALL resume normal operation on the first edge with rst_n=1.

Verification
REQ-030 SHALL cover: reset during SELF_CLEAN with countdown=97 -> next edge state=000, countdown=0, third_used=0.
REQ-031 SHALL cover: power, menu, level3, then 60 ticks -> state=101 with countdown 60..1, then state=100, countdown=0, third_used=1.
REQ-032 SHALL cover: after REQ-031, menu, menu, level3 -> state stays 010; level3 is rejected.
REQ-033 SHALL cover: MODE_SELECT with no press for 10 ticks -> state=001 after the 10th tick; a tick on the entry cycle is not counted.
REQ-034 SHALL cover: in MODE_SELECT, power+level2 pressed in the same cycle -> state=000; menu+level1 pressed together -> state=001.
REQ-035 SHALL cover: SELF_CLEAN for 180 ticks -> state=001; power at tick 50 -> state=000, countdown=0.

Source files
------------

// File: rtl/hood_state_controller.sv
// Cooker-hood operating-state controller: power, mode selection, fan levels,
// boost (third level) with a one-shot-per-power-cycle limit, and timed self-clean.
module hood_state_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       power_btn,
    input  logic       menu_btn,
    input  logic       level1_btn,
    input  logic       level2_btn,
    input  logic       level3_btn,
    input  logic       clean_btn,
    output logic [2:0] state,
    output logic [7:0] countdown,
    output logic       third_used
);

    typedef enum logic [2:0] {
        OFF          = 3'b000,
        STANDBY      = 3'b001,
        MODE_SELECT  = 3'b010,
        FIRST_LEVEL  = 3'b011,
        SECOND_LEVEL = 3'b100,
        THIRD_LEVEL  = 3'b101,
        SELF_CLEAN   = 3'b110
    } state_t;

    localparam logic [7:0] MENU_TIMEOUT = 8'd10;
    localparam logic [7:0] THIRD_TIME   = 8'd60;
    localparam logic [7:0] CLEAN_TIME   = 8'd180;

    state_t     state_q;
    logic [7:0] countdown_q;
    logic       third_used_q;

    assign state      = state_q;
    assign countdown  = countdown_q;
    assign third_used = third_used_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= OFF;
            countdown_q  <= '0;
            third_used_q <= 1'b0;
        end else if (power_btn) begin
            // Power outranks everything; from an unencoded state it also lands in OFF.
            state_q      <= (state_q == OFF) ? STANDBY : OFF;
            countdown_q  <= '0;
            third_used_q <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    countdown_q <= '0;
                end
                STANDBY: begin
                    if (menu_btn) begin
                        state_q     <= MODE_SELECT;
                        countdown_q <= MENU_TIMEOUT;
                    end
                end
                MODE_SELECT: begin
                    // A rejected level3 press still masks the lower-priority buttons.
                    if (menu_btn) begin
                        state_q     <= STANDBY;
                        countdown_q <= '0;
                    end else if (level3_btn && !third_used_q) begin
                        state_q      <= THIRD_LEVEL;
                        countdown_q  <= THIRD_TIME;
                        third_used_q <= 1'b1;
                    end else if (level2_btn && !level3_btn) begin
                        state_q     <= SECOND_LEVEL;
                        countdown_q <= '0;
                    end else if (level1_btn && !level3_btn) begin
                        state_q     <= FIRST_LEVEL;
                        countdown_q <= '0;
                    end else if (clean_btn && !level3_btn) begin
                        state_q     <= SELF_CLEAN;
                        countdown_q <= CLEAN_TIME;
                    end else if (tick_1s) begin
                        if (countdown_q <= 8'd1) begin
                            state_q     <= STANDBY;
                            countdown_q <= '0;
                        end else begin
                            countdown_q <= countdown_q - 8'd1;
                        end
                    end
                end
                FIRST_LEVEL: begin
                    countdown_q <= '0;
                    if (menu_btn) begin
                        state_q <= STANDBY;
                    end else if (level2_btn) begin
                        state_q <= SECOND_LEVEL;
                    end
                end
                SECOND_LEVEL: begin
                    countdown_q <= '0;
                    if (menu_btn) begin
                        state_q <= STANDBY;
                    end else if (level1_btn) begin
                        state_q <= FIRST_LEVEL;
                    end
                end
                THIRD_LEVEL: begin
                    if (tick_1s) begin
                        if (countdown_q <= 8'd1) begin
                            state_q     <= SECOND_LEVEL;
                            countdown_q <= '0;
                        end else begin
                            countdown_q <= countdown_q - 8'd1;
                        end
                    end
                end
                SELF_CLEAN: begin
                    if (tick_1s) begin
                        if (countdown_q <= 8'd1) begin
                            state_q     <= STANDBY;
                            countdown_q <= '0;
                        end else begin
                            countdown_q <= countdown_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_q      <= OFF;
                    countdown_q  <= '0;
                    third_used_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
